// File: rtl/core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_pkg : shared widths, fetch FSM states and fetch-entry type
// Rev 1.0
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_stage_if : PC-unit, instruction-memory and decode signals of fetch
// Rev 1.0
// ----------------------------------------------------------------------------
interface fetch_stage_if;
    import core_pkg::*;

    logic [XLEN-1:0] pc;
    logic            branch_taken;
    logic            pc_write;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [ILEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport slave (
        input  pc, branch_taken, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        output pc_write, imem_req_valid, imem_addr, id_valid, id_instr, id_pc
    );

    modport master (
        output pc, branch_taken, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        input  pc_write, imem_req_valid, imem_addr, id_valid, id_instr, id_pc
    );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo : registered FIFO with synchronous flush, power-of-two depth
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             flush_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic      [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_stage : in-order instruction fetch with PC-tagged return queue
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_stage
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fetch_stage_if.slave fif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            tag_push, tag_pop, tag_full, tag_empty;
    logic [CW-1:0]   tag_count;
    logic [XLEN-1:0] tag_head;

    logic            data_push, data_pop, data_full, data_empty;
    logic [CW-1:0]   data_count;
    fetch_entry_t    data_in, data_head;

    logic [CW-1:0]   inflight, occupancy;
    logic            rsp_retire, id_fire, req_valid, fire;

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (fif.branch_taken),
        .push_i  (tag_push),
        .wdata_i (fif.pc),
        .pop_i   (tag_pop),
        .rdata_o (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (fif.branch_taken),
        .push_i  (data_push),
        .wdata_i (data_in),
        .pop_i   (data_pop),
        .rdata_o (data_head),
        .full_o  (data_full),
        .empty_o (data_empty),
        .count_o (data_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;

        // In DRAIN the tag queue is empty; outstanding requests live only in drop_cnt.
        inflight   = (state_q == RUN) ? tag_count : drop_cnt_q;
        occupancy  = tag_count + data_count;
        id_fire    = !data_empty && fif.id_ready;
        rsp_retire = fif.imem_rsp_valid && (inflight != '0);

        // Reset gates the request path so it drops as soon as reset asserts.
        req_valid  = reset && (state_q == RUN) && !fif.branch_taken &&
                     ((occupancy < CW'(DEPTH)) || id_fire);
        fire       = req_valid && fif.imem_req_ready;

        tag_push   = fire;
        tag_pop    = (state_q == RUN) && fif.imem_rsp_valid && !tag_empty;
        data_push  = tag_pop && !fif.branch_taken;
        data_pop   = id_fire;
        data_in    = '{pc: tag_head, instr: fif.imem_rsp_data};

        if (fif.branch_taken) begin
            drop_cnt_d = inflight - CW'(rsp_retire);
            state_d    = ((state_q == DRAIN) || (drop_cnt_d != '0)) ? DRAIN : RUN;
        end else if (state_q == DRAIN) begin
            if (drop_cnt_q == '0) begin
                state_d = RUN;
            end else if (fif.imem_rsp_valid) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    assign fif.imem_req_valid = req_valid;
    assign fif.imem_addr      = fif.pc;
    assign fif.pc_write       = reset && (fire || fif.branch_taken);
    assign fif.id_valid       = !data_empty;
    assign fif.id_instr       = data_head.instr;
    assign fif.id_pc          = data_head.pc;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(fif.imem_rsp_valid && (state_q == RUN) && (tag_count == '0)));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(tag_push && tag_full && !tag_pop));
    a_data_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(data_push && data_full && !data_pop));
    a_occupancy_bound: assert property (@(posedge clk) disable iff (!reset)
        occupancy <= CW'(DEPTH));

endmodule : fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC unit.
- Takes the current PC and issues in-order requests to instruction memory.
- Buffers returned instructions with their PCs in a small queue and presents them to decode over a valid/ready handshake.
- Drives PCWrite back to the PC unit, so the PC advances only when a fetch is accepted. Flushes all buffered and in-flight work on BranchTaken.

Parameters:
- XLEN, 64, width of PC and addresses.
- ILEN, 32, instruction width.
- DEPTH, 2, max instructions outstanding plus buffered; power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  reset is asynchronous and active-low.
- pc  in  XLEN  current PC from the PC unit.
- branch_taken  in  1  redirect/flush; the PC unit loads its target at the same edge.
- pc_write  out  1  PC-advance enable to the PC unit.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XLEN  request address, equal to pc.
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, no backpressure.
- imem_rsp_data  in  ILEN  fetched instruction.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode consumes this cycle.
- id_instr  out  ILEN  head instruction.
- id_pc  out  XLEN  PC of head instruction.

Behaviour:
- Reset (async assert, sync release): FSM=RUN; queues empty; inflight=0; drop_cnt=0. Outputs: pc_write=0, imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0.
- Queues:
  - Tag queue: PCs of issued-but-unanswered requests, DEPTH entries.
  - Data queue: {pc, instr} pairs, DEPTH entries.
  - occupancy = inflight + data_count; invariant occupancy ≤ DEPTH.
- FSM states:
  - RUN: imem_req_valid = !branch_taken && (occupancy < DEPTH), or occupancy == DEPTH with id_fire this cycle. fire = imem_req_valid && imem_req_ready. On fire, push pc into the tag queue.
  - DRAIN: imem_req_valid=0; discard every imem_rsp_valid and decrement drop_cnt; move to RUN in the cycle after drop_cnt reaches 0.
- pc_write = fire || branch_taken. It is combinational, so the PC increments by 4 at the same edge a fetch is accepted.
- Response in RUN: pop the tag queue, push {tag, imem_rsp_data} into the data queue in the same cycle.
- Response-to-id_valid latency: 1 cycle; data queue is registered.
- id_fire = id_valid && id_ready pops the head. Push and pop in the same cycle are both honoured; count is unchanged.
- branch_taken (any state, highest priority):
  - No request is issued that cycle.
  - Data queue and tag queue are cleared; id_valid=0 from the next cycle.
  - drop_cnt = inflight, counting a response arriving that same cycle as already retired.
  - Next state is DRAIN if drop_cnt > 0, else RUN.
  - branch_taken while in DRAIN: drop_cnt is recomputed the same way; state stays DRAIN.
- Full: occupancy == DEPTH with no id_fire → no request issued, pc_write=0, PC holds.
- Empty: id_valid=0; id_instr and id_pc hold their last values (don't-care).
- Pointers wrap modulo DEPTH. Counters are clog2(DEPTH)+1 bits; never overflow (assertion).
- Reset asserted mid-operation: everything clears immediately. In-flight memory responses after release are ignored; the memory is reset by the same signal.
- A response with inflight == 0 and FSM in RUN is illegal; flag it with an assertion.

Decomposition:
- Shared package (core_pkg): XLEN and ILEN constants; fetch FSM state enum {RUN, DRAIN}; fetch-entry struct {pc, instr}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count, flush input).
  - Instantiated twice: tag queue (XLEN wide) and data queue (XLEN+ILEN wide).

Test Plan:
1. Reset release, imem_req_ready=1, 1-cycle response latency, id_ready=1 → fetches at 0x0, 0x4, 0x8, 0xC. id_pc sequence 0x0, 0x4, 0x8, 0xC; one instruction per cycle after 2-cycle fill; pc_write=1 continuously.
2. id_ready=0 for 6 cycles → exactly 2 requests issued (DEPTH=2). pc_write=0 and pc frozen at 0x8. On id_ready=1, the instructions for 0x0 and 0x4 emerge in order, none lost or duplicated.
3. imem_req_ready=0 for 3 cycles → imem_req_valid stays 1 with imem_addr stable at 0x8; pc_write=0; pc does not advance.
4. With 2 requests in flight (3-cycle latency), branch_taken=1 with target 100 → data queue emptied; FSM enters DRAIN with drop_cnt=2. Both stale responses are dropped, then fetch resumes at 100 and the first id_pc is 100, followed by 104.
5. branch_taken and imem_rsp_valid in the same cycle, inflight=1 → response discarded; drop_cnt=0; FSM stays RUN; next request at the target address.
6. Reset asserted mid-stream with the data queue full → id_valid, imem_req_valid and pc_write drop asynchronously. After release, the first id_pc is 0x0.
